// File: rtl/skel_frame_ram.sv
// rtl/skel_frame_ram.sv - ping-pong two-bank pixel RAM with pass/convergence bookkeeping
module skel_frame_ram #(
  parameter int N          = 8,
  parameter int pixelWidth = 8,
  parameter int bitSize    = 6,
  parameter int cntWidth   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  load_en,
  input  logic                  harrisBit,
  input  logic [bitSize:0]      primary_address,
  input  logic [bitSize:0]      dual_read_address,
  input  logic [pixelWidth-1:0] data_in,
  input  logic                  pass_done,
  output logic [pixelWidth-1:0] primary_output,
  output logic [pixelWidth-1:0] dual_output,
  output logic                  swap_ack,
  output logic                  changed,
  output logic                  converged,
  output logic                  pass_incomplete,
  output logic [cntWidth-1:0]   pass_count
);

  localparam int NN = N * N;
  localparam int AW = bitSize + 1;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(NN + 1);

  logic [pixelWidth-1:0] bank0 [NN];
  logic [pixelWidth-1:0] bank1 [NN];

  logic                  bank_sel;
  logic [CW-1:0]         wr_cnt;

  logic [IW-1:0]         p_idx;
  logic [IW-1:0]         d_idx;
  logic                  p_ok;
  logic                  d_ok;
  logic [pixelWidth-1:0] p_rd;
  logic [pixelWidth-1:0] d_rd;
  logic [pixelWidth-1:0] wval;
  logic                  load_wr;
  logic                  pass_wr;
  logic                  accept;
  logic                  changed_eff;
  logic [CW-1:0]         cnt_eff;

  assign p_idx = primary_address[IW-1:0];
  assign d_idx = dual_read_address[IW-1:0];
  assign p_ok  = {1'b0, primary_address} < (AW + 1)'(NN);
  assign d_ok  = {1'b0, dual_read_address} < (AW + 1)'(NN);

  // p_rd doubles as the compare port: in pass mode it reads the read bank at the write address
  assign p_rd = bank_sel ? bank1[p_idx] : bank0[p_idx];
  assign d_rd = bank_sel ? bank1[d_idx] : bank0[d_idx];

  assign wval    = harrisBit ? data_in : '0;
  assign load_wr = we && load_en && p_ok;
  assign pass_wr = we && !load_en && p_ok;
  assign accept  = pass_done && !load_en;

  assign changed_eff = changed || (pass_wr && (wval != p_rd));
  assign cnt_eff     = (pass_wr && (wr_cnt != CW'(NN))) ? wr_cnt + CW'(1) : wr_cnt;

  // Load writes the read bank, pass writes the other one
  always_ff @(posedge clk) begin
    if (load_wr || pass_wr) begin
      if (bank_sel ^ pass_wr) begin
        bank1[p_idx] <= wval;
      end else begin
        bank0[p_idx] <= wval;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primary_output <= '0;
      dual_output    <= '0;
    end else begin
      primary_output <= p_ok ? p_rd : '0;
      dual_output    <= d_ok ? d_rd : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel        <= 1'b0;
      wr_cnt          <= '0;
      changed         <= 1'b0;
      converged       <= 1'b0;
      pass_incomplete <= 1'b0;
      pass_count      <= '0;
      swap_ack        <= 1'b0;
    end else begin
      swap_ack <= accept;
      if (accept) begin
        bank_sel        <= ~bank_sel;
        converged       <= !changed_eff && (cnt_eff == CW'(NN));
        pass_incomplete <= cnt_eff != CW'(NN);
        pass_count      <= (pass_count == '1) ? pass_count : pass_count + cntWidth'(1);
        changed         <= 1'b0;
        wr_cnt          <= '0;
      end else begin
        changed <= changed_eff;
        wr_cnt  <= cnt_eff;
      end
    end
  end

endmodule

// File: tb/tb_skel_frame_ram.sv
// tb/tb_skel_frame_ram.sv - scoreboard bench for skel_frame_ram against a bank-array reference model
module tb_skel_frame_ram;
  localparam int N = 8, PW = 8, BS = 6, CWD = 8, NN = 64;

  logic          clk = 0, rst = 0, we = 0, load_en = 0, harrisBit = 1, pass_done = 0;
  logic [BS:0]   primary_address = 0, dual_read_address = 0;
  logic [PW-1:0] data_in = 0;
  logic [PW-1:0] primary_output, dual_output;
  logic          swap_ack, changed, converged, pass_incomplete;
  logic [CWD-1:0] pass_count;

  skel_frame_ram #(.N(N), .pixelWidth(PW), .bitSize(BS), .cntWidth(CWD)) dut (
    .clk(clk), .rst(rst), .we(we), .load_en(load_en), .harrisBit(harrisBit),
    .primary_address(primary_address), .dual_read_address(dual_read_address),
    .data_in(data_in), .pass_done(pass_done),
    .primary_output(primary_output), .dual_output(dual_output),
    .swap_ack(swap_ack), .changed(changed), .converged(converged),
    .pass_incomplete(pass_incomplete), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct { bit conv; bit inc; int pc; } st_t;
  logic [PW-1:0]   m [2][NN];
  int              sel = 0, cnt = 0, pc = 0;
  bit              chg = 0, conv = 0, inc = 0;
  st_t             st_q[$];
  logic [2*PW-1:0] rd_q[$];
  logic            rd_v = 0, rd_v_d = 0;
  logic [2*PW-1:0] e;
  st_t             s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mread(input int a);
    return (a < NN) ? m[sel][a] : '0;
  endfunction

  task automatic model_write(input int a, input logic [PW-1:0] d, input bit h, input bit ld);
    logic [PW-1:0] wv;
    wv = h ? d : '0;
    if (a < NN) begin
      if (ld) m[sel][a] = wv;
      else begin
        if (wv != m[sel][a]) chg = 1;
        m[1-sel][a] = wv;
        if (cnt < NN) cnt++;
      end
    end
  endtask

  task automatic model_pd(input bit ld);
    if (!ld) begin
      conv = !chg && (cnt == NN);
      inc  = cnt < NN;
      pc   = (pc == 255) ? 255 : pc + 1;
      sel  = 1 - sel;
      chg  = 0;
      cnt  = 0;
      st_q.push_back('{conv, inc, pc});
    end
  endtask

  // One clock of stimulus; read expectations are taken before the same-cycle write/swap
  task automatic cyc(input bit w, input bit ld, input bit h, input int a, input logic [PW-1:0] d,
                     input bit pd, input bit rv, input int a2);
    we = w; load_en = ld; harrisBit = h; primary_address = a[BS:0]; data_in = d;
    pass_done = pd; dual_read_address = a2[BS:0]; rd_v = rv;
    if (rv) rd_q.push_back({mread(a), mread(a2)});
    if (w) model_write(a, d, h, ld);
    if (pd) model_pd(ld);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 1, 0, 8'd0, 0, 0, 0);
  endtask

  always @(posedge clk) rd_v_d <= rd_v;

  always @(negedge clk) begin
    if (rd_v_d) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("primary_output", {24'd0, primary_output}, {24'd0, e[2*PW-1:PW]});
        chk("dual_output", {24'd0, dual_output}, {24'd0, e[PW-1:0]});
      end
    end
    if (swap_ack) begin
      if (st_q.size() == 0) chk("unexpected_swap_ack", 1, 0);
      else begin
        s = st_q.pop_front();
        chk("changed_after_swap", {31'd0, changed}, 0);
        chk("converged", {31'd0, converged}, {31'd0, s.conv});
        chk("pass_incomplete", {31'd0, pass_incomplete}, {31'd0, s.inc});
        chk("pass_count", {24'd0, pass_count}, s.pc);
      end
    end
  end

  initial begin
    int n, kind, a, a2;
    bit h, pd_last;
    logic [PW-1:0] d;

    #1 rst = 1;
    #1;
    chk("rst_primary_output", {24'd0, primary_output}, 0);
    chk("rst_dual_output", {24'd0, dual_output}, 0);
    chk("rst_swap_ack", {31'd0, swap_ack}, 0);
    chk("rst_changed", {31'd0, changed}, 0);
    chk("rst_converged", {31'd0, converged}, 0);
    chk("rst_pass_incomplete", {31'd0, pass_incomplete}, 0);
    chk("rst_pass_count", {24'd0, pass_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < NN; i++) cyc(1, 1, 1, i, PW'(i), 0, 0, 0);
    cyc(0, 0, 1, 5, 8'd0, 0, 1, 63);
    cyc(1, 1, 1, 7, 8'hAA, 0, 1, 7);
    cyc(1, 1, 1, 7, 8'd7, 0, 1, 7);

    for (int i = 0; i < NN; i++) cyc(1, 0, 1, i, mread(i), 0, 0, 0);
    chk("changed_identical_pass", {31'd0, changed}, {31'd0, chg});
    cyc(0, 0, 1, 0, 8'd0, 1, 0, 0);
    idle();

    for (int i = 0; i < NN; i++) cyc(1, 0, (i != 10), i, mread(i), 0, 0, 0);
    chk("changed_harris_pass", {31'd0, changed}, {31'd0, chg});
    cyc(0, 0, 1, 0, 8'd0, 1, 0, 0);
    cyc(0, 0, 1, 10, 8'd0, 0, 1, 11);

    for (int i = 0; i < NN - 1; i++) cyc(1, 0, 1, i, PW'($urandom), 0, 0, 0);
    cyc(1, 0, 1, NN - 1, PW'($urandom), 1, 0, 0);
    cyc(0, 0, 1, 63, 8'd0, 0, 1, 62);

    for (int i = 0; i < NN - 1; i++) cyc(1, 0, 1, i, mread(i), 0, 0, 0);
    cyc(0, 0, 1, 0, 8'd0, 1, 0, 0);
    idle();

    for (int p = 0; p < 8; p++) begin
      kind = $urandom_range(0, 2);
      n = (kind == 2) ? $urandom_range(40, 90) : NN;
      pd_last = $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        a  = (kind == 2) ? $urandom_range(0, 127) : i;
        a2 = $urandom_range(0, 127);
        d  = (kind == 0) ? mread(a) : PW'($urandom);
        h  = (kind == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
        cyc(1, 0, h, a, d, (pd_last && i == n - 1), ($urandom_range(0, 3) == 0), a2);
      end
      if (!pd_last) cyc(0, 0, 1, 0, 8'd0, 1, 1, $urandom_range(0, 127));
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, $urandom_range(0, 127), 8'd0, 0, 1, $urandom_range(0, 127));
    end

    cyc(0, 0, 1, 1, 8'd0, 0, 1, 2);
    for (int i = 0; i < 30; i++) cyc(1, 0, 1, i, PW'($urandom), 0, 0, 0);
    we = 0;
    #3 rst = 1;
    #1;
    chk("async_rst_primary_output", {24'd0, primary_output}, 0);
    chk("async_rst_dual_output", {24'd0, dual_output}, 0);
    chk("async_rst_changed", {31'd0, changed}, 0);
    chk("async_rst_converged", {31'd0, converged}, 0);
    chk("async_rst_pass_incomplete", {31'd0, pass_incomplete}, 0);
    chk("async_rst_pass_count", {24'd0, pass_count}, 0);
    chk("async_rst_swap_ack", {31'd0, swap_ack}, 0);
    sel = 0; cnt = 0; chg = 0; conv = 0; inc = 0; pc = 0;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, $urandom_range(0, 63), 8'd0, 0, 1, $urandom_range(0, 63));

    for (int p = 0; p < 260; p++) begin
      cyc(0, 0, 1, 0, 8'd0, 1, 0, 0);
      idle();
    end
    cyc(0, 1, 1, 0, 8'd0, 1, 0, 0);
    repeat (3) idle();
    chk("load_mode_pass_done_count", {24'd0, pass_count}, pc);
    chk("load_mode_pass_done_saturated", {24'd0, pass_count}, 255);

    repeat (2) idle();
    chk("pending_swap_acks", st_q.size(), 0);
    chk("pending_reads", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
